// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 16x phase-accumulator oversampling, 2-FF synchronizer,
// false-start rejection and 3-sample majority voting per bit.
module uart_rx_oversampled #(
    parameter int SOURCE_FREQ       = 25_000_000,
    parameter int BAUD              = 115200,
    parameter int ACCUMULATOR_WIDTH = 20,
    parameter int STOP_BITS         = 1
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_complete,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int AW = ACCUMULATOR_WIDTH;
    localparam longint unsigned INC_WIDE =
        (((64'd1 << AW) * 64'd16 * 64'(BAUD)) + 64'(SOURCE_FREQ / 2)) / 64'(SOURCE_FREQ);
    localparam logic [AW:0] INC = INC_WIDE[AW:0];

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_BIT,
        RX_DATA,
        RX_STOP_BIT,
        RX_COMPLETE
    } rx_state_t;

    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [AW:0] r_acc;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_rx_prev;
    logic [3:0]  r_tcnt;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_stop_cnt;
    logic [2:0]  r_samp;
    logic [7:0]  r_sr;
    logic [7:0]  r_rx_byte;
    logic        r_complete;
    logic        r_frame_err;

    logic        w_tick;
    logic [3:0]  w_tcnt_inc;
    logic        w_fall;
    logic        w_maj;
    logic        w_maj_now;
    logic        w_last_stop;
    logic        w_restart;
    logic        w_done_set;
    logic        w_err_set;

    assign w_tick      = r_acc[AW];
    assign w_tcnt_inc  = r_tcnt + 4'd1;
    assign w_fall      = r_rx_prev & ~r_sync2;
    assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    // Final stop bit is judged on the tick of its third sample, so that sample comes live from rx_s.
    assign w_maj_now   = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);
    assign w_last_stop = (r_stop_cnt <= 2'd1);

    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge sourceClk) begin
        if (reset) r_state <= RX_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state_next = RX_START_BIT;
                    w_restart    = 1'b1;
                end
            end
            RX_START_BIT: begin
                if (w_tick && w_tcnt_inc == 4'd15)
                    w_state_next = w_maj ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_tick && w_tcnt_inc == 4'd15 && r_bit_cnt == 3'd7)
                    w_state_next = RX_STOP_BIT;
            end
            RX_STOP_BIT: begin
                if (w_tick) begin
                    if (w_last_stop && w_tcnt_inc == 4'd9) begin
                        w_state_next = w_maj_now ? RX_COMPLETE : RX_IDLE;
                        w_done_set   = w_maj_now;
                        w_err_set    = ~w_maj_now;
                    end else if (!w_last_stop && w_tcnt_inc == 4'd15 && !w_maj) begin
                        w_state_next = RX_IDLE;
                        w_err_set    = 1'b1;
                    end
                end
            end
            RX_COMPLETE: w_state_next = RX_IDLE;
            default:     w_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sourceClk) begin
        if (reset) begin
            r_acc       <= '0;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_tcnt      <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= '0;
            r_samp      <= '1;
            r_sr        <= '0;
            r_rx_byte   <= '0;
            r_complete  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx_in;
            r_sync2     <= r_sync1;
            r_rx_prev   <= r_sync2;
            r_complete  <= w_done_set;
            r_frame_err <= w_err_set;

            if (w_restart)   r_acc <= '0;
            else if (w_tick) r_acc <= {1'b0, r_acc[AW-1:0]} + INC;
            else             r_acc <= r_acc + INC;

            if (w_restart) begin
                r_tcnt <= '0;
            end else if (w_tick && r_state != RX_IDLE && r_state != RX_COMPLETE) begin
                if (r_state == RX_START_BIT && w_tcnt_inc == 4'd15) r_tcnt <= '0;
                else                                                 r_tcnt <= w_tcnt_inc;
                case (w_tcnt_inc)
                    4'd7:    r_samp[0] <= r_sync2;
                    4'd8:    r_samp[1] <= r_sync2;
                    4'd9:    r_samp[2] <= r_sync2;
                    default: ;
                endcase
            end

            if (w_tick && w_tcnt_inc == 4'd15) begin
                if (r_state == RX_START_BIT) r_bit_cnt <= '0;
                if (r_state == RX_DATA) begin
                    r_sr <= {w_maj, r_sr[7:1]};
                    if (r_bit_cnt == 3'd7) r_stop_cnt <= 2'(STOP_BITS);
                    else                   r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                if (r_state == RX_STOP_BIT && !w_last_stop) r_stop_cnt <= r_stop_cnt - 2'd1;
            end

            if (w_done_set) r_rx_byte <= r_sr;
        end
    end

    assign rx_byte      = r_rx_byte;
    assign rx_complete  = r_complete;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: a frame-level scoreboard predicts every
// strobe and the held byte, plus literal expectations per scenario.
module tb_uart_rx_oversampled;

    localparam int BIT_LEN = 217;   // 25 MHz / 115200 baud
    localparam int BIT_FAST = 212;  // sender at +2.5% baud
    localparam int BIT_SLOW = 223;  // sender at -2.5% baud
    localparam int LAT_MIN = 2074 - 16;
    localparam int LAT_MAX = 2074 + 16;

    logic       sourceClk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_complete;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx_oversampled dut (
        .sourceClk   (sourceClk),
        .reset       (reset),
        .rx_in       (rx_in),
        .rx_byte     (rx_byte),
        .rx_complete (rx_complete),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #20 sourceClk = ~sourceClk;

    typedef struct {
        logic       good;
        logic [7:0] data;
        int         t_start;
    } frame_t;

    frame_t     exp_q[$];
    frame_t     cur;
    logic [7:0] got_q[$];
    logic [7:0] model_byte = 8'h00;
    logic       prev_pulse = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(posedge sourceClk) cyc <= cyc + 1;

    // Scoreboard: each strobe must match the oldest frame sent, within the latency window.
    always @(negedge sourceClk) begin
        if (!reset) begin
            if (rx_complete || rx_frame_err) begin
                check("no_consecutive_strobe", 32'(prev_pulse), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'({rx_complete, rx_frame_err}), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    lat = cyc - cur.t_start;
                    check("strobe_kind", 32'({rx_complete, rx_frame_err}), cur.good ? 32'd2 : 32'd1);
                    if (lat < LAT_MIN || lat > LAT_MAX)
                        check("strobe_latency", 32'(lat), 32'(LAT_MIN));
                    else
                        check("strobe_latency", 32'(lat), 32'(lat > LAT_MAX ? LAT_MAX : lat));
                    if (cur.good) model_byte = cur.data;
                end
                if (rx_complete) begin
                    n_done++;
                    got_q.push_back(rx_byte);
                end
                if (rx_frame_err) n_err++;
            end
            check("rx_byte_held", 32'(rx_byte), 32'(model_byte));
            prev_pulse = rx_complete | rx_frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sourceClk);
            #1;
        end
    endtask

    // Drives one 8N1 frame, one cycle per loop pass; abort_at >= 0 cuts it short unscored.
    task automatic send_frame(input logic [7:0] data, input int bit_len, input logic stop_val,
                              input int abort_at);
        logic [9:0] bits;
        bits = {stop_val, data, 1'b0};
        if (abort_at < 0) exp_q.push_back('{good: stop_val, data: data, t_start: cyc});
        for (int c = 0; c < 10 * bit_len; c++) begin
            if (c == abort_at) return;
            rx_in = bits[c / bit_len];
            step(1);
        end
        rx_in = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        rx_in = 1'b1;
        step(n);
        reset = 1'b0;
        model_byte = 8'h00;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rx_byte"}, 32'(rx_byte), 32'h00);
        check({tag, "_rx_complete"}, 32'(rx_complete), 32'd0);
        check({tag, "_rx_frame_err"}, 32'(rx_frame_err), 32'd0);
        check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    endtask

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, g0;
        do_reset(4);
        check_reset_state("reset");

        // 1: single frame
        step(50);
        d0 = n_done;
        send_frame(8'hA5, BIT_LEN, 1'b1, -1);
        step(300);
        check("t1_complete_count", 32'(n_done - d0), 32'd1);
        check("t1_rx_byte", 32'(rx_byte), 32'hA5);
        check("t1_frame_err_count", 32'(n_err), 32'd0);
        check("t1_busy_idle", 32'(rx_busy), 32'd0);

        // 2: back-to-back frames, zero idle bits
        g0 = got_q.size();
        send_frame(8'h00, BIT_LEN, 1'b1, -1);
        send_frame(8'hFF, BIT_LEN, 1'b1, -1);
        send_frame(8'h55, BIT_LEN, 1'b1, -1);
        step(300);
        check("t2_complete_count", 32'(got_q.size() - g0), 32'd3);
        if (got_q.size() >= g0 + 3) begin
            check("t2_byte0", 32'(got_q[g0]), 32'h00);
            check("t2_byte1", 32'(got_q[g0 + 1]), 32'hFF);
            check("t2_byte2", 32'(got_q[g0 + 2]), 32'h55);
        end

        // 3: ~0.23-bit glitch is a false start
        d0 = n_done;
        e0 = n_err;
        rx_in = 1'b0;
        step(50);
        rx_in = 1'b1;
        step(20);
        check("t3_busy_during_glitch", 32'(rx_busy), 32'd1);
        step(BIT_LEN - 20);
        check("t3_busy_idle", 32'(rx_busy), 32'd0);
        check("t3_no_complete", 32'(n_done - d0), 32'd0);
        check("t3_no_frame_err", 32'(n_err - e0), 32'd0);
        send_frame(8'h3C, BIT_LEN, 1'b1, -1);
        step(300);
        check("t3_rx_byte", 32'(rx_byte), 32'h3C);

        // 4: framing error right after reset, then a good frame
        do_reset(2);
        step(20);
        d0 = n_done;
        e0 = n_err;
        send_frame(8'h81, BIT_LEN, 1'b0, -1);
        rx_in = 1'b1;
        step(BIT_LEN);
        check("t4_frame_err_count", 32'(n_err - e0), 32'd1);
        check("t4_no_complete", 32'(n_done - d0), 32'd0);
        check("t4_rx_byte_kept", 32'(rx_byte), 32'h00);
        send_frame(8'h7E, BIT_LEN, 1'b1, -1);
        step(300);
        check("t4_rx_byte", 32'(rx_byte), 32'h7E);

        // 5: sender baud offset +2.5% and -2.5%
        d0 = n_done;
        send_frame(8'hC3, BIT_FAST, 1'b1, -1);
        step(2 * BIT_LEN);
        check("t5_fast_rx_byte", 32'(rx_byte), 32'hC3);
        do_reset(1);
        step(20);
        send_frame(8'hC3, BIT_SLOW, 1'b1, -1);
        step(300);
        check("t5_complete_count", 32'(n_done - d0), 32'd2);
        check("t5_slow_rx_byte", 32'(rx_byte), 32'hC3);

        // 6: reset in the middle of data bit 4, then a fresh frame
        d0 = n_done;
        send_frame(8'h99, BIT_LEN, 1'b1, (11 * BIT_LEN) / 2);
        check("t6_busy_mid_frame", 32'(rx_busy), 32'd1);
        do_reset(1);
        check_reset_state("t6_reset");
        step(3 * BIT_LEN);
        check("t6_no_partial_complete", 32'(n_done - d0), 32'd0);
        send_frame(8'h42, BIT_LEN, 1'b1, -1);
        step(300);
        check("t6_complete_count", 32'(n_done - d0), 32'd1);
        check("t6_rx_byte", 32'(rx_byte), 32'h42);
        check("t6_busy_idle", 32'(rx_busy), 32'd0);

        check("all_frames_seen", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
